// File: rtl/dds_ctrl_pkg.sv
// Shared types for the DDS sweep controller: sweep modes, FSM states and default widths.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package dds_ctrl_pkg;

  localparam int PW_DEF = 32;  // frequency/phase word width, matches the DDS core
  localparam int DW_DEF = 16;  // dwell counter width

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    RSVD   = 2'd3   // treated exactly like SINGLE
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire flags the last cycle of a dwell period.
// Latency: expire is combinational from the count; a load takes effect next edge.
// Backpressure: none; counting is gated by en only.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load value into the counter (wins over counting)
//   en        - count enable; expire is only asserted while enabled
//   value     - reload value (dwell - 1 semantics: value+1 cycles per period)
//   expire    - high in the cycle where the counter has reached zero
module dds_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] value,
  output logic          expire
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer driving DDS freq/phase/en: single, sawtooth or triangle chirps.
// Latency: start sampled at edge N gives busy/dds_en/start word from cycle N+1; each word lasts dwell+1 cycles.
// Backpressure: config accepted only in IDLE (cfg_ready); start ignored outside IDLE; abort always wins.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   cfg_valid / cfg_ready       - config write strobe / accept (high in IDLE)
//   cfg_start_fw, cfg_stop_fw   - sweep endpoints (unsigned)
//   cfg_step_fw                 - step magnitude (unsigned)
//   cfg_dwell                   - each word held for cfg_dwell+1 cycles
//   cfg_mode                    - 0 single, 1 sawtooth, 2 triangle, 3 as single
//   cfg_phase                   - static phase offset, presented on dds_phase
//   start, abort                - sweep trigger / immediate stop
//   busy, done                  - sweep running / one-cycle completion pulse
//   dds_en, dds_freq, dds_phase - DDS control words
//   dir_up                      - current stepping direction
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [PW-1:0] cfg_start_fw,
  input  logic [PW-1:0] cfg_stop_fw,
  input  logic [PW-1:0] cfg_step_fw,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic [PW-1:0] cfg_phase,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          dds_en,
  output logic [PW-1:0] dds_freq,
  output logic [PW-1:0] dds_phase,
  output logic          dir_up
);

  sweep_state_e state, state_nxt;

  // Latched configuration
  logic [PW-1:0] start_fw, start_nxt;
  logic [PW-1:0] stop_fw,  stop_nxt;
  logic [PW-1:0] step_fw,  step_nxt;
  logic [DW-1:0] dwell,    dwell_nxt;
  sweep_mode_e   mode,     mode_nxt;
  logic [PW-1:0] phase_nxt;

  // Live sweep endpoints; triangle mode swaps them at every reversal
  logic [PW-1:0] cur_from, cur_from_nxt;
  logic [PW-1:0] cur_to,   cur_to_nxt;

  logic [PW-1:0] freq_nxt;
  logic          dir_nxt;

  // Config as seen by a start in the same cycle as a write
  logic [PW-1:0] eff_start;
  logic [PW-1:0] eff_stop;
  logic [DW-1:0] eff_dwell;
  logic          cfg_we;

  logic          degenerate;
  logic          at_end;

  logic          tmr_load;
  logic          tmr_en;
  logic [DW-1:0] tmr_value;
  logic          tmr_expire;

  // One clamped step toward target. The PW+1-bit arithmetic exposes both the
  // carry out of an up step and the borrow of a down step, so overshoot in
  // either direction lands exactly on the target and never wraps.
  function automatic logic [PW-1:0] step_toward(
    input logic [PW-1:0] cur,
    input logic [PW-1:0] step,
    input logic [PW-1:0] target,
    input logic          up
  );
    logic [PW:0] sum;
    logic [PW:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (up) begin
      step_toward = (sum > {1'b0, target}) ? target : sum[PW-1:0];
    end else begin
      step_toward = (diff[PW] || (diff[PW-1:0] < target)) ? target : diff[PW-1:0];
    end
  endfunction

  dds_dwell_timer #(
    .DW (DW)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  assign tmr_en = (state == RUN);

  assign cfg_we    = (state == IDLE) && cfg_valid;
  assign eff_start = cfg_valid ? cfg_start_fw : start_fw;
  assign eff_stop  = cfg_valid ? cfg_stop_fw  : stop_fw;
  assign eff_dwell = cfg_valid ? cfg_dwell    : dwell;

  // A zero step or coincident endpoints can never make progress, so the
  // current word is treated as the endpoint after every dwell.
  assign degenerate = (step_fw == '0) || (cur_from == cur_to);
  assign at_end     = degenerate || (dds_freq == cur_to);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    start_nxt    = start_fw;
    stop_nxt     = stop_fw;
    step_nxt     = step_fw;
    dwell_nxt    = dwell;
    mode_nxt     = mode;
    phase_nxt    = dds_phase;
    cur_from_nxt = cur_from;
    cur_to_nxt   = cur_to;
    freq_nxt     = dds_freq;
    dir_nxt      = dir_up;
    tmr_load     = 1'b0;
    tmr_value    = dwell;

    if (cfg_we) begin
      start_nxt = cfg_start_fw;
      stop_nxt  = cfg_stop_fw;
      step_nxt  = cfg_step_fw;
      dwell_nxt = cfg_dwell;
      mode_nxt  = sweep_mode_e'(cfg_mode);
      phase_nxt = cfg_phase;
    end

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt    = RUN;
          freq_nxt     = eff_start;
          cur_from_nxt = eff_start;
          cur_to_nxt   = eff_stop;
          dir_nxt      = (eff_stop >= eff_start);
          tmr_load     = 1'b1;
          tmr_value    = eff_dwell;
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr_expire) begin
          // Reload the dwell for the next word; harmless when finishing.
          tmr_load = 1'b1;
          if (at_end) begin
            case (mode)
              SAW: begin
                freq_nxt = cur_from;
              end
              TRI: begin
                // Step away from the endpoint immediately so it is only
                // emitted once per reversal.
                if (!degenerate) begin
                  cur_from_nxt = cur_to;
                  cur_to_nxt   = cur_from;
                  dir_nxt      = !dir_up;
                  freq_nxt     = step_toward(dds_freq, step_fw, cur_from, !dir_up);
                end
              end
              default: begin
                state_nxt = FINISH;
              end
            endcase
          end else begin
            freq_nxt = step_toward(dds_freq, step_fw, cur_to, dir_up);
          end
        end
      end

      FINISH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_fw  <= '0;
      stop_fw   <= '0;
      step_fw   <= '0;
      dwell     <= '0;
      mode      <= SINGLE;
      dds_phase <= '0;
      cur_from  <= '0;
      cur_to    <= '0;
      dds_freq  <= '0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
      dds_en    <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      start_fw  <= start_nxt;
      stop_fw   <= stop_nxt;
      step_fw   <= step_nxt;
      dwell     <= dwell_nxt;
      mode      <= mode_nxt;
      dds_phase <= phase_nxt;
      cur_from  <= cur_from_nxt;
      cur_to    <= cur_to_nxt;
      dds_freq  <= freq_nxt;
      dir_up    <= dir_nxt;
      busy      <= (state_nxt == RUN);
      dds_en    <= (state_nxt == RUN);
      done      <= (state_nxt == FINISH);
      cfg_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed word sequences per sweep mode,
// handshake corner cases and asynchronous reset in the middle of a sweep.
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start_fw;
  logic [31:0] cfg_stop_fw;
  logic [31:0] cfg_step_fw;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_phase;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        dds_en;
  logic [31:0] dds_freq;
  logic [31:0] dds_phase;
  logic        dir_up;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_w[$];
  bit          exp_d[$];

  dds_sweep_ctrl #(
    .PW (32),
    .DW (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start_fw (cfg_start_fw),
    .cfg_stop_fw  (cfg_stop_fw),
    .cfg_step_fw  (cfg_step_fw),
    .cfg_dwell    (cfg_dwell),
    .cfg_mode     (cfg_mode),
    .cfg_phase    (cfg_phase),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .dds_en       (dds_en),
    .dds_freq     (dds_freq),
    .dds_phase    (dds_phase),
    .dir_up       (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                        input logic [15:0] dw, input logic [1:0] md, input logic [31:0] ph);
    cfg_start_fw = s;
    cfg_stop_fw  = e;
    cfg_step_fw  = st;
    cfg_dwell    = dw;
    cfg_mode     = md;
    cfg_phase    = ph;
    cfg_valid    = 1'b1;
    step_cyc();
    cfg_valid    = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step_cyc();
    start = 1'b0;
  endtask

  // Expect each word of exp_w (direction exp_d) for dwell+1 cycles while running.
  task automatic expect_words(input int dwell, input string tag);
    for (int k = 0; k < exp_w.size(); k++) begin
      for (int c = 0; c <= dwell; c++) begin
        chk({tag, "_freq"}, dds_freq, exp_w[k]);
        chk({tag, "_dir"}, dir_up, exp_d[k]);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_en"}, dds_en, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdy"}, cfg_ready, 0);
        step_cyc();
      end
    end
  endtask

  task automatic expect_finish(input logic [31:0] last, input string tag);
    chk({tag, "_done_hi"}, done, 1);
    chk({tag, "_busy_lo"}, busy, 0);
    chk({tag, "_en_lo"}, dds_en, 0);
    chk({tag, "_hold"}, dds_freq, last);
    chk({tag, "_rdy_lo"}, cfg_ready, 0);
    step_cyc();
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_rdy_hi"}, cfg_ready, 1);
    chk({tag, "_hold2"}, dds_freq, last);
  endtask

  task automatic expect_abort(input logic [31:0] last, input string tag);
    abort = 1'b1;
    step_cyc();
    abort = 1'b0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, dds_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hold"}, dds_freq, last);
    step_cyc();
    chk({tag, "_done2"}, done, 0);
    chk({tag, "_rdy"}, cfg_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_start_fw = '0;
    cfg_stop_fw = '0;
    cfg_step_fw = '0;
    cfg_dwell = '0;
    cfg_mode = '0;
    cfg_phase = '0;
    start = 1'b0;
    abort = 1'b0;

    // Reset state
    step_cyc();
    step_cyc();
    chk("rst_busy", busy, 0);
    chk("rst_en", dds_en, 0);
    chk("rst_done", done, 0);
    chk("rst_freq", dds_freq, 0);
    chk("rst_phase", dds_phase, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_rdy", cfg_ready, 1);
    rst = 1'b0;
    step_cyc();

    // Up single sweep, dwell 2
    do_cfg(32'h0100_0000, 32'h0140_0000, 32'h0010_0000, 16'd2, 2'd0, 32'h1234_5678);
    chk("up_phase", dds_phase, 32'h1234_5678);
    go();
    exp_w = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000, 32'h0140_0000};
    exp_d = '{1, 1, 1, 1, 1};
    expect_words(2, "up");
    expect_finish(32'h0140_0000, "up_fin");

    // Down sweep with final clamp to stop
    do_cfg(32'h0000_0100, 32'h0000_0010, 32'h0000_0070, 16'd0, 2'd0, 32'h0000_00AA);
    go();
    exp_w = '{32'h100, 32'h090, 32'h020, 32'h010};
    exp_d = '{0, 0, 0, 0};
    expect_words(0, "dn");
    expect_finish(32'h010, "dn_fin");

    // Triangle, then abort mid-sweep
    do_cfg(32'h10, 32'h30, 32'h10, 16'd0, 2'd2, 32'h0);
    go();
    exp_w = '{32'h10, 32'h20, 32'h30, 32'h20, 32'h10, 32'h20, 32'h30, 32'h20};
    exp_d = '{1, 1, 1, 0, 0, 1, 1, 0};
    expect_words(0, "tri");
    chk("tri_pre_abort", dds_freq, 32'h10);
    expect_abort(32'h10, "tri_ab");

    // Sawtooth, then abort
    do_cfg(32'h10, 32'h30, 32'h10, 16'd0, 2'd1, 32'h0);
    go();
    exp_w = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30, 32'h10};
    exp_d = '{1, 1, 1, 1, 1, 1, 1};
    expect_words(0, "saw");
    chk("saw_pre_abort", dds_freq, 32'h20);
    expect_abort(32'h20, "saw_ab");

    // start and cfg_valid together: new config is used
    cfg_start_fw = 32'h500;
    cfg_stop_fw  = 32'h520;
    cfg_step_fw  = 32'h10;
    cfg_dwell    = 16'd1;
    cfg_mode     = 2'd0;
    cfg_phase    = 32'h0000_BEEF;
    cfg_valid    = 1'b1;
    go();
    cfg_valid    = 1'b0;
    chk("same_phase", dds_phase, 32'h0000_BEEF);
    exp_w = '{32'h500, 32'h510, 32'h520};
    exp_d = '{1, 1, 1};
    expect_words(1, "same");
    expect_finish(32'h520, "same_fin");

    // Config writes during RUN are ignored
    do_cfg(32'h40, 32'h10, 32'h10, 16'd0, 2'd0, 32'h0000_AAAA);
    go();
    chk("ign_f0", dds_freq, 32'h40);
    cfg_start_fw = 32'h999;
    cfg_stop_fw  = 32'hFFF;
    cfg_mode     = 2'd2;
    cfg_phase    = 32'h0000_5555;
    cfg_valid    = 1'b1;
    chk("ign_rdy", cfg_ready, 0);
    step_cyc();
    cfg_valid    = 1'b0;
    chk("ign_f1", dds_freq, 32'h30);
    step_cyc();
    exp_w = '{32'h20, 32'h10};
    exp_d = '{0, 0};
    expect_words(0, "ign");
    expect_finish(32'h10, "ign_fin");
    chk("ign_phase", dds_phase, 32'h0000_AAAA);
    go();
    exp_w = '{32'h40, 32'h30, 32'h20, 32'h10};
    exp_d = '{0, 0, 0, 0};
    expect_words(0, "ign2");
    expect_finish(32'h10, "ign2_fin");

    // start and abort together: stays idle
    start = 1'b1;
    abort = 1'b1;
    step_cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_rdy", cfg_ready, 1);
    chk("sa_freq", dds_freq, 32'h10);
    step_cyc();
    chk("sa_busy2", busy, 0);
    chk("sa_done", done, 0);

    // Zero step, single: start word for dwell+1 cycles then done
    do_cfg(32'h77, 32'h99, 32'h0, 16'd3, 2'd0, 32'h0);
    go();
    exp_w = '{32'h77};
    exp_d = '{1};
    expect_words(3, "z");
    expect_finish(32'h77, "z_fin");

    // Asynchronous reset between clock edges mid-sweep
    do_cfg(32'h0100_0000, 32'h0140_0000, 32'h0010_0000, 16'd2, 2'd0, 32'h1111_2222);
    go();
    step_cyc();
    step_cyc();
    step_cyc();
    chk("ar_pre", dds_freq, 32'h0110_0000);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_en", dds_en, 0);
    chk("ar_freq", dds_freq, 0);
    chk("ar_phase", dds_phase, 0);
    chk("ar_dir", dir_up, 1);
    chk("ar_done", done, 0);
    chk("ar_rdy", cfg_ready, 1);
    step_cyc();
    rst = 1'b0;
    step_cyc();
    do_cfg(32'h10, 32'h30, 32'h10, 16'd0, 2'd0, 32'h0);
    go();
    exp_w = '{32'h10, 32'h20, 32'h30};
    exp_d = '{1, 1, 1};
    expect_words(0, "ar2");
    expect_finish(32'h30, "ar2_fin");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer that drives the frequency and phase control words of the `DDS` core to produce programmable frequency sweeps (chirps): single-shot, repeating sawtooth, or triangle. It sits between a register/config interface and the DDS `freq`/`phase`/`en` inputs, replacing free-running testbench stimulus with cycle-exact hardware stepping. A start/abort/busy/done handshake lets a host or higher-level scheduler trigger and monitor sweeps.

## Interface
- `PW`, 32: width of frequency/phase control words; matches the DDS `PW`.
- `DW`, 16: width of the dwell counter.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: config write strobe, accepted only when `cfg_ready`.
- `cfg_ready` out 1: high in IDLE.
- `cfg_start_fw` in PW: start frequency word, unsigned.
- `cfg_stop_fw` in PW: stop frequency word, unsigned.
- `cfg_step_fw` in PW: step magnitude, unsigned.
- `cfg_dwell` in DW: each frequency is held for `cfg_dwell+1` cycles.
- `cfg_mode` in 2: 0 single, 1 sawtooth repeat, 2 triangle; 3 behaves as 0.
- `cfg_phase` in PW: static phase offset.
- `start` in 1: start request, sampled in IDLE only.
- `abort` in 1: stop immediately from any state.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at normal sweep completion.
- `dds_en` out 1: DDS enable.
- `dds_freq` out PW: DDS frequency word.
- `dds_phase` out PW: DDS phase word.
- `dir_up` out 1: current step direction.

## Operation
- States: IDLE, RUN, FINISH.
- Reset: state IDLE; all config regs 0; `dds_freq`, `dds_phase` 0; `dds_en`, `busy`, `done` 0; `dir_up` 1.
- IDLE: if `cfg_valid`, latch all `cfg_*`. `dds_phase` follows the latched `cfg_phase`.
- If `start` and `cfg_valid` occur in the same cycle, the sweep uses the newly written config.
- IDLE & `start` & !`abort` → RUN. Load `dds_freq` = start word. `dir_up` = (stop ≥ start). Load dwell counter = `cfg_dwell`.
- RUN: dwell counter decrements each cycle. At 0, take the next frequency:
  - Up: next = min(freq+step, stop). Compare with PW+1-bit sum; no wrap is ever emitted.
  - Down: next = max(freq−step, stop). Underflow clamps to stop.
- Reaching the stop word, after its full dwell:
  - Mode 0/3: → FINISH.
  - Mode 1: reload start word.
  - Mode 2: swap the roles of start and stop, toggle `dir_up`, and keep stepping. The endpoint is emitted once per reversal, not twice.
- `step` = 0 or start == stop: the start word is held for one dwell, then treated as the endpoint. Modes 1/2 then hold the word indefinitely until abort.
- FINISH: `done`=1 for one cycle, then IDLE. `dds_freq` holds the last word.
- `abort` (any state, priority over `start`): → IDLE next edge. `busy`=0, `dds_en`=0, no `done`. `dds_freq` holds.
- `busy` = `dds_en` = (state == RUN). Both are registered.

## Timing
- All outputs are registered.
- Start sampled at edge N: `busy`, `dds_en`, and `dds_freq`=start word are valid from cycle N+1.
- Each frequency is valid for exactly `cfg_dwell+1` consecutive cycles. There are no gap cycles between steps.
- Single sweep with K distinct words: RUN lasts K·(dwell+1) cycles. `done` is high in the first cycle after RUN, coinciding with `busy`=0. `cfg_ready` returns the following cycle.
- Abort sampled at edge M: `busy`=0 from M+1.
- Config writes during RUN/FINISH are ignored. `cfg_ready`=0.

## Structure
- Package `dds_ctrl_pkg`: `sweep_mode_e` (SINGLE, SAW, TRI, RSVD), `sweep_state_e` (IDLE, RUN, FINISH).
- Sub-module `dds_dwell_timer`: loadable down-counter with `load`, `value`, and `expire` pulse, parameterised by DW.
- Top level holds the FSM, config registers, and clamped step adder/subtractor.

## Test plan
- Up single: start=0x0100_0000, stop=0x0140_0000, step=0x0010_0000, dwell=2. Expect words 0x0100_0000, 0x0110_0000, 0x0120_0000, 0x0130_0000, 0x0140_0000, each for 3 cycles. `busy` for 15 cycles, `done` once, `dds_freq` holds 0x0140_0000.
- Clamp/down: start=0x0000_0100, stop=0x0000_0010, step=0x0000_0070, dwell=0. Expect 0x100, 0x090, 0x020, 0x010, then `done`; no wrap.
- Triangle: start=0x10, stop=0x30, step=0x10, dwell=0, mode 2. Expect 0x10, 0x20, 0x30, 0x20, 0x10, 0x20, …, with `dir_up` toggling at endpoints and no `done`; abort mid-sweep drops `busy` next cycle with no `done`.
- Sawtooth: same words, mode 1. Expect 0x10, 0x20, 0x30, 0x10, 0x20, … continuous.
- Handshake: `start`+`cfg_valid` in the same cycle uses the new config. `start`+`abort` together → stays IDLE. `cfg_valid` during RUN is ignored. `step`=0 single → start word for dwell+1 cycles, then `done`.
- Async reset asserted mid-RUN, between clock edges: all outputs go to reset values immediately. After release, a new start works normally.
